register_arbiter: RTL and testbench

REGISTER_ARBITER -- requirements
Module: register_arbiter

---
 rtl/register_arbiter_pkg.sv | 22 ++
 rtl/register_arbiter_storage.sv | 32 +++
 rtl/register_arbiter.sv | 96 +++++++++
 tb/tb_register_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_arbiter_pkg.sv
// Shared types and default widths for the two-port register arbiter.
package register_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned NUM_REQ    = 2;

    typedef logic req_id_t;

    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        req_id_t               owner;
    } cmd_t;

    function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/register_arbiter_storage.sv
// Register file: async active-high reset, load-over-store priority, registered read.
module reg_storage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else if (load) begin
            rdata <= mem[addr];
        end else if (store) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/register_arbiter.sv
// Two-requester round-robin front end to a register file: one command per cycle,
// loads answer two cycles after acceptance on the owner's rsp_valid bit.
module register_arbiter
    import register_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              idle
);

    req_id_t     prio_q;
    logic [1:0]  grant_c;
    logic        accept_c;
    req_id_t     accept_id_c;
    cmd_t        cmd_d;
    cmd_t        cmd_q;
    logic        load_c;
    logic        store_c;

    // Grant is combinational; prio_q names the requester favoured on a tie.
    always_comb begin
        grant_c = 2'b00;
        if (reset) begin
            case (req_valid)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = prio_q ? 2'b10 : 2'b01;
                default: grant_c = 2'b00;
            endcase
        end
    end

    assign req_ready   = grant_c;
    assign accept_c    = |grant_c;
    assign accept_id_c = grant_c[1];

    always_comb begin
        cmd_d       = '0;
        cmd_d.valid = accept_c;
        cmd_d.owner = accept_id_c;
        if (accept_id_c) begin
            cmd_d.write = req_write[1];
            cmd_d.addr  = ADDR_W_DEF'(req_addr1);
            cmd_d.wdata = DATA_W_DEF'(req_wdata1);
        end else begin
            cmd_d.write = req_write[0];
            cmd_d.addr  = ADDR_W_DEF'(req_addr0);
            cmd_d.wdata = DATA_W_DEF'(req_wdata0);
        end
    end

    assign load_c  = cmd_q.valid & ~cmd_q.write;
    assign store_c = cmd_q.valid & cmd_q.write;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prio_q    <= 1'b0;
            cmd_q     <= '0;
            rsp_valid <= 2'b00;
            idle      <= 1'b1;
        end else begin
            cmd_q     <= cmd_d;
            rsp_valid <= load_c ? id_onehot(cmd_q.owner) : 2'b00;
            idle      <= !accept_c && !load_c;
            if (accept_c) begin
                prio_q <= ~accept_id_c;
            end
        end
    end

    reg_storage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clock (clock),
        .reset (~reset),
        .load  (load_c),
        .store (store_c),
        .addr  (ADDR_W'(cmd_q.addr)),
        .wdata (DATA_W'(cmd_q.wdata)),
        .rdata (rsp_rdata)
    );

endmodule

// File: tb/tb_register_arbiter.sv
// Directed scoreboard bench for register_arbiter.
module tb_register_arbiter;

    logic       clock;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_write;
    logic [3:0] req_addr0;
    logic [3:0] req_addr1;
    logic [7:0] req_wdata0;
    logic [7:0] req_wdata1;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_rdata;
    logic       idle;

    typedef struct packed {
        logic [1:0] vld;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem_m [16];
    logic       m_prio;
    logic [7:0] last_data;
    int         vectors;
    int         miscompares;
    int         accepted;

    register_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .idle       (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each pulse, otherwise checks data hold.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (rsp_valid !== 2'b00) begin
                chk("rsp_unexpected", 32'(rsp_valid), (sb.size() != 0) ? 32'(rsp_valid) : 32'h0);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(e.vld));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                    last_data = e.data;
                end
            end else begin
                chk("rdata_hold", 32'(rsp_rdata), 32'(last_data));
            end
        end
    end

    task automatic step(input logic [1:0] v, input logic [1:0] w,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        output logic [1:0] got);
        logic [1:0] g;
        logic       id;
        logic [3:0] a;
        logic [7:0] d;
        @(negedge clock);
        req_valid  = v;
        req_write  = w;
        req_addr0  = a0;
        req_addr1  = a1;
        req_wdata0 = d0;
        req_wdata1 = d1;
        #1;
        case (v)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = m_prio ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        got = req_ready;
        chk("req_ready", 32'(req_ready), 32'(g));
        if (g != 2'b00) begin
            id = g[1];
            a  = id ? a1 : a0;
            d  = id ? d1 : d0;
            accepted++;
            if (w[id]) mem_m[a] = d;
            else sb.push_back({g, mem_m[a]});
            m_prio = ~id;
        end
    endtask

    task automatic quiet();
        @(negedge clock);
        req_valid = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clock);
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'h0);
        repeat (2) @(negedge clock);
        #1;
        chk("idle_after", 32'(idle), 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        req_valid = 2'b11;
        reset     = 1'b0;
        sb.delete();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        m_prio    = 1'b0;
        last_data = 8'h00;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rdata", 32'(rsp_rdata), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        @(negedge clock);
        chk("rst_rsp_valid2", 32'(rsp_valid), 32'h0);
        req_valid = 2'b00;
        reset     = 1'b1;
    endtask

    initial begin
        logic [1:0] got;
        logic [1:0] order [4];
        int         acc0;
        vectors     = 0;
        miscompares = 0;
        accepted    = 0;
        last_data   = 8'h00;
        m_prio      = 1'b0;
        reset       = 1'b1;
        req_valid   = 2'b00;
        req_write   = 2'b00;
        req_addr0   = 4'h0;
        req_addr1   = 4'h0;
        req_wdata0  = 8'h00;
        req_wdata1  = 8'h00;
        #2;
        do_reset();

        // Single load from req0 with explicit latency checks
        step(2'b01, 2'b00, 4'd5, 4'd0, 8'h00, 8'h00, got);
        @(posedge clock); #1;
        req_valid = 2'b00;
        chk("ld_e0_rsp", 32'(rsp_valid), 32'h0);
        chk("ld_e0_idle", 32'(idle), 32'h0);
        @(posedge clock); #1;
        chk("ld_e1_rsp", 32'(rsp_valid), 32'h1);
        chk("ld_e1_data", 32'(rsp_rdata), 32'h0);
        @(posedge clock); #1;
        chk("ld_e2_rsp", 32'(rsp_valid), 32'h0);
        chk("ld_e2_idle", 32'(idle), 32'h1);
        drain();

        // Store then immediate load of the same address from req1
        step(2'b10, 2'b10, 4'd0, 4'd3, 8'h00, 8'hA5, got);
        step(2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00, got);
        quiet();
        drain();
        chk("st_ld_last", 32'(last_data), 32'hA5);

        // Contention after seeding distinct data
        step(2'b01, 2'b01, 4'd1, 4'd0, 8'h11, 8'h00, got);
        step(2'b10, 2'b10, 4'd0, 4'd2, 8'h00, 8'h22, got);
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, got);
            order[i] = got;
        end
        quiet();
        chk("cont_g0", 32'(order[0]), 32'h1);
        chk("cont_g1", 32'(order[1]), 32'h2);
        chk("cont_g2", 32'(order[2]), 32'h1);
        chk("cont_g3", 32'(order[3]), 32'h2);
        drain();

        // Throughput: 16 stores then 16 loads back-to-back from req0
        do_reset();
        acc0 = accepted;
        for (int i = 0; i < 16; i++)
            step(2'b01, 2'b01, 4'(i), 4'd0, 8'(i * 17), 8'h00, got);
        for (int i = 0; i < 16; i++)
            step(2'b01, 2'b00, 4'(i), 4'd0, 8'h00, 8'h00, got);
        quiet();
        chk("thru_accepted", 32'(accepted - acc0), 32'd32);
        drain();
        chk("thru_last", 32'(last_data), 32'hFF);

        // Reset in flight drops the pending load and clears storage
        step(2'b01, 2'b01, 4'd7, 4'd0, 8'h3C, 8'h00, got);
        step(2'b01, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00, got);
        do_reset();
        repeat (3) @(negedge clock);
        #1;
        chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
        step(2'b01, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00, got);
        quiet();
        drain();
        chk("mid_rst_data", 32'(last_data), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
